// File: rtl/giraffe_pkg.sv
// Shared constants for the Giraffe ADC capture path: sample tags and the
// encoding of the UART transmit state machine.
package giraffe_pkg;

    // Tag placed above the ADC result in each UART word.
    localparam logic [1:0] TAG_MAIN = 2'b11;
    localparam logic [1:0] TAG_SUB  = 2'b00;

    // Transmit FSM states.
    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_REQ  = 2'd1,
        TX_WAIT = 2'd2
    } tx_state_e;

    // A main-ADC ack always wins the tag, even when the sub ack is also high.
    function automatic logic [1:0] select_tag(input logic main_ack);
        return main_ack ? TAG_MAIN : TAG_SUB;
    endfunction

endpackage

// File: rtl/adc_sample_packer_sync_fifo.sv
// Single-clock FIFO with occupancy count. Full and empty are taken from the
// count, so the pointers only need to wrap modulo DEPTH. A push into a full
// FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo
    import giraffe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk_i,
    input  logic                       nrst_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           din_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             push_eff;
    logic             pop_eff;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign dout_o  = mem_q[rd_ptr_q];

    // Decide which operations actually take effect and the resulting pointers/count.
    always_comb begin
        pop_eff  = pop_i && !empty_o;
        push_eff = push_i && (!full_o || pop_eff);
        wr_ptr_d = push_eff ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_eff  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q;
        if (push_eff && !pop_eff) begin
            level_d = level_q + LW'(1);
        end else if (pop_eff && !push_eff) begin
            level_d = level_q - LW'(1);
        end
    end

    // Pointer and occupancy registers; reset empties the FIFO.
    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_i) begin
        if (push_eff) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/adc_sample_packer.sv
// Capture stage between the Giraffe ADC and the UART transmitter: brings the
// ADC acks and data into clk_50M, turns each rising ack into a tagged word,
// buffers it, and hands words to the UART one at a time via wreq/rdy.
module adc_sample_packer
    import giraffe_pkg::*;
#(
    parameter int N_bit       = 6,
    parameter int N_data      = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk_50M,
    input  logic                          nrst,
    input  logic                          adc_ack,
    input  logic                          adc_ack_sub,
    input  logic [N_bit-1:0]              dout_adc,
    input  logic                          uart_rdy,
    output logic                          wreq,
    output logic [N_data-1:0]             wdata,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    if (N_data != N_bit + 2) begin : g_width_check
        $error("adc_sample_packer: N_data must equal N_bit+2");
    end

    logic [SYNC_STAGES-1:0] ack_sync_q;
    logic [SYNC_STAGES-1:0] ack_sub_sync_q;
    logic [N_bit-1:0]       dout_sync_q [SYNC_STAGES];
    logic                   ack_prev_q;

    logic                   ack_main;
    logic                   ack_s;
    logic                   sample_evt;
    logic [N_data-1:0]      sample_word;

    logic                   fifo_full;
    logic                   fifo_empty;
    logic [N_data-1:0]      fifo_dout;
    logic                   pop;

    tx_state_e              state_q, state_d;
    logic                   wreq_q, wreq_d;
    logic [N_data-1:0]      wdata_q, wdata_d;
    logic                   overflow_q, overflow_d;

    // Acks and data share the same flop depth so the data seen in the event
    // cycle is the value that was stable while the ack was high.
    assign ack_main    = ack_sync_q[SYNC_STAGES-1];
    assign ack_s       = ack_main | ack_sub_sync_q[SYNC_STAGES-1];
    assign sample_evt  = ack_s & ~ack_prev_q;
    assign sample_word = {select_tag(ack_main), dout_sync_q[SYNC_STAGES-1]};

    // Synchroniser chains plus the previous-cycle ack used for edge detection.
    always_ff @(posedge clk_50M) begin
        if (!nrst) begin
            ack_sync_q     <= '0;
            ack_sub_sync_q <= '0;
            ack_prev_q     <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                dout_sync_q[i] <= '0;
            end
        end else begin
            ack_sync_q     <= {ack_sync_q[SYNC_STAGES-2:0], adc_ack};
            ack_sub_sync_q <= {ack_sub_sync_q[SYNC_STAGES-2:0], adc_ack_sub};
            ack_prev_q     <= ack_s;
            dout_sync_q[0] <= dout_adc;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                dout_sync_q[i] <= dout_sync_q[i-1];
            end
        end
    end

    sync_fifo #(
        .WIDTH (N_data),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_50M),
        .nrst_i  (nrst),
        .push_i  (sample_evt),
        .pop_i   (pop),
        .din_i   (sample_word),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    // Transmit FSM state register.
    always_ff @(posedge clk_50M) begin
        if (!nrst) begin
            state_q <= TX_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Transmit FSM next state: WAIT holds until the UART shows it took the word.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TX_IDLE: if (!fifo_empty && uart_rdy) state_d = TX_REQ;
            TX_REQ:  state_d = TX_WAIT;
            TX_WAIT: if (!uart_rdy) state_d = TX_IDLE;
            default: state_d = TX_IDLE;
        endcase
    end

    // Transmit FSM outputs: pop decision, next wreq/wdata, sticky overflow.
    always_comb begin
        pop        = (state_q == TX_IDLE) && !fifo_empty && uart_rdy;
        wreq_d     = (state_q == TX_REQ);
        wdata_d    = pop ? fifo_dout : wdata_q;
        overflow_d = overflow_q | (sample_evt & fifo_full & ~pop);
    end

    // Registered outputs; wdata only moves on a pop so it stays put for the frame.
    always_ff @(posedge clk_50M) begin
        if (!nrst) begin
            wreq_q     <= 1'b0;
            wdata_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wreq_q     <= wreq_d;
            wdata_q    <= wdata_d;
            overflow_q <= overflow_d;
        end
    end

    assign wreq     = wreq_q;
    assign wdata    = wdata_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_adc_sample_packer.sv
// Directed bench for adc_sample_packer: a queue of expected UART words is fed
// from the stimulus, a UART model answers wreq, and every wreq is compared.
module tb_adc_sample_packer;

    localparam int FRAME = 6;

    logic       clk_50M = 1'b0;
    logic       nrst;
    logic       adc_ack;
    logic       adc_ack_sub;
    logic [5:0] dout_adc;
    logic       hold;
    logic       force_rdy;
    logic       uart_idle;
    wire        uart_rdy;
    logic       wreq;
    logic [7:0] wdata;
    logic       overflow;
    logic [4:0] fifo_level;

    int         nvec = 0;
    int         nfail = 0;
    int         wreq_cnt = 0;
    logic [7:0] expq [$];

    assign uart_rdy = hold ? 1'b0 : (force_rdy ? 1'b1 : uart_idle);

    adc_sample_packer #(
        .N_bit       (6),
        .N_data      (8),
        .FIFO_DEPTH  (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk_50M     (clk_50M),
        .nrst        (nrst),
        .adc_ack     (adc_ack),
        .adc_ack_sub (adc_ack_sub),
        .dout_adc    (dout_adc),
        .uart_rdy    (uart_rdy),
        .wreq        (wreq),
        .wdata       (wdata),
        .overflow    (overflow),
        .fifo_level  (fifo_level)
    );

    always #10 clk_50M = ~clk_50M;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // UART model: drops rdy the cycle after a request and stays busy a frame.
    initial begin
        uart_idle = 1'b1;
        forever begin
            @(negedge clk_50M);
            if (wreq === 1'b1) begin
                @(negedge clk_50M);
                uart_idle = 1'b0;
                repeat (FRAME) @(negedge clk_50M);
                uart_idle = 1'b1;
            end
        end
    end

    // Reset discards every buffered or pending word.
    always @(posedge clk_50M) begin
        if (nrst === 1'b0) expq.delete();
    end

    // Compare every request against the expected word order.
    initial begin
        logic       prev_wreq;
        logic [7:0] prev_wdata;
        logic [7:0] exp_w;
        prev_wreq  = 1'b0;
        prev_wdata = 8'h00;
        forever begin
            @(negedge clk_50M);
            if (nrst === 1'b1 && wreq === 1'b1) begin
                wreq_cnt++;
                check("wreq_single_cycle", {31'd0, prev_wreq}, 32'd0);
                check("wdata_before_wreq", {24'd0, wdata}, {24'd0, prev_wdata});
                if (expq.size() == 0) begin
                    nvec++;
                    nfail++;
                    $display("FAIL unexpected_wreq: got wdata %0h, expected no request", wdata);
                end else begin
                    exp_w = expq.pop_front();
                    check("wdata_order", {24'd0, wdata}, {24'd0, exp_w});
                end
            end
            prev_wreq  = wreq;
            prev_wdata = wdata;
        end
    end

    // One ack pulse (2 cycles high, 2 low); the model records the tagged word.
    task automatic pulse(input logic main, input logic sub, input logic [5:0] val, input logic drop);
        @(negedge clk_50M);
        dout_adc    = val;
        adc_ack     = main;
        adc_ack_sub = sub;
        if (!drop) expq.push_back({(main ? 2'b11 : 2'b00), val});
        repeat (2) @(negedge clk_50M);
        adc_ack     = 1'b0;
        adc_ack_sub = 1'b0;
        repeat (2) @(negedge clk_50M);
    endtask

    // Ack held for 20 cycles; checks one request, its latency and a literal word.
    task automatic one_sample(input string name, input logic main, input logic sub,
                              input logic [5:0] val, input logic [7:0] lit);
        int         lat;
        int         base;
        logic [7:0] got;
        lat  = -1;
        got  = 8'hxx;
        base = wreq_cnt;
        @(negedge clk_50M);
        dout_adc    = val;
        adc_ack     = main;
        adc_ack_sub = sub;
        expq.push_back({(main ? 2'b11 : 2'b00), val});
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk_50M);
            if (wreq === 1'b1 && lat < 0) begin
                lat = i;
                got = wdata;
            end
            if (i == 20) begin
                adc_ack     = 1'b0;
                adc_ack_sub = 1'b0;
            end
        end
        check({name, "_latency"}, lat, 32'd5);
        check({name, "_word"}, {24'd0, got}, {24'd0, lit});
        check({name, "_wreq_count"}, wreq_cnt - base, 32'd1);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (expq.size() != 0 && n < 3000) begin
            @(negedge clk_50M);
            n++;
        end
        check({name, "_drained"}, expq.size(), 32'd0);
        repeat (12) @(negedge clk_50M);
    endtask

    initial begin
        int base;
        nrst        = 1'b0;
        adc_ack     = 1'b0;
        adc_ack_sub = 1'b0;
        dout_adc    = 6'h00;
        hold        = 1'b0;
        force_rdy   = 1'b0;
        repeat (3) @(negedge clk_50M);
        check("reset_wreq", {31'd0, wreq}, 32'd0);
        check("reset_wdata", {24'd0, wdata}, 32'd0);
        check("reset_level", {27'd0, fifo_level}, 32'd0);
        check("reset_overflow", {31'd0, overflow}, 32'd0);
        nrst = 1'b1;
        repeat (2) @(negedge clk_50M);

        // Single samples and tag priority.
        one_sample("main_2A", 1'b1, 1'b0, 6'h2A, 8'hEA);
        check("main_overflow", {31'd0, overflow}, 32'd0);
        one_sample("sub_05", 1'b0, 1'b1, 6'h05, 8'h05);
        one_sample("both_05", 1'b1, 1'b1, 6'h05, 8'hC5);

        // Backpressure: fill to 16 with the UART held busy, then drain in order.
        hold = 1'b1;
        base = wreq_cnt;
        for (int i = 0; i < 16; i++) pulse(1'b1, 1'b0, 6'(i), 1'b0);
        repeat (4) @(negedge clk_50M);
        check("bp_level_full", {27'd0, fifo_level}, 32'd16);
        check("bp_no_wreq", wreq_cnt - base, 32'd0);
        check("bp_overflow", {31'd0, overflow}, 32'd0);
        hold = 1'b0;
        wait_drain("bp");
        check("bp_wreq_count", wreq_cnt - base, 32'd16);
        check("bp_level_empty", {27'd0, fifo_level}, 32'd0);

        // Overflow: 17th sample into a full FIFO is lost, flag is sticky.
        hold = 1'b1;
        for (int i = 0; i < 16; i++) pulse(1'b1, 1'b0, 6'(i + 16), 1'b0);
        pulse(1'b1, 1'b0, 6'h3F, 1'b1);
        repeat (4) @(negedge clk_50M);
        check("ovf_level", {27'd0, fifo_level}, 32'd16);
        check("ovf_flag", {31'd0, overflow}, 32'd1);
        hold = 1'b0;
        wait_drain("ovf");
        check("ovf_sticky", {31'd0, overflow}, 32'd1);
        check("ovf_level_empty", {27'd0, fifo_level}, 32'd0);

        @(negedge clk_50M);
        nrst = 1'b0;
        @(negedge clk_50M);
        nrst = 1'b1;
        check("rst_clears_overflow", {31'd0, overflow}, 32'd0);
        check("rst_clears_wdata", {24'd0, wdata}, 32'd0);

        // Push and pop in the same cycle on a full FIFO.
        hold = 1'b1;
        base = wreq_cnt;
        for (int i = 0; i < 16; i++) pulse(1'b1, 1'b0, 6'(i + 6'h10), 1'b0);
        repeat (4) @(negedge clk_50M);
        check("pp_level_before", {27'd0, fifo_level}, 32'd16);
        @(negedge clk_50M);
        dout_adc = 6'h2B;
        adc_ack  = 1'b1;
        expq.push_back(8'hEB);
        repeat (2) @(negedge clk_50M);
        hold = 1'b0;
        @(negedge clk_50M);
        check("pp_level_same", {27'd0, fifo_level}, 32'd16);
        check("pp_no_overflow", {31'd0, overflow}, 32'd0);
        @(negedge clk_50M);
        adc_ack = 1'b0;
        wait_drain("pp");
        check("pp_wreq_count", wreq_cnt - base, 32'd17);
        check("pp_overflow_after", {31'd0, overflow}, 32'd0);

        // Reset mid-transfer: one word in WAIT, five buffered.
        hold = 1'b1;
        for (int i = 0; i < 6; i++) pulse(1'b1, 1'b0, 6'(i + 6'h30), 1'b0);
        repeat (4) @(negedge clk_50M);
        check("mid_level_6", {27'd0, fifo_level}, 32'd6);
        force_rdy = 1'b1;
        hold      = 1'b0;
        repeat (8) @(negedge clk_50M);
        check("mid_level_5", {27'd0, fifo_level}, 32'd5);
        base = wreq_cnt;
        nrst = 1'b0;
        @(negedge clk_50M);
        check("mid_rst_wreq", {31'd0, wreq}, 32'd0);
        check("mid_rst_wdata", {24'd0, wdata}, 32'd0);
        check("mid_rst_level", {27'd0, fifo_level}, 32'd0);
        nrst      = 1'b1;
        force_rdy = 1'b0;
        repeat (30) @(negedge clk_50M);
        check("mid_no_wreq_after_rst", wreq_cnt - base, 32'd0);
        one_sample("after_rst_11", 1'b1, 1'b0, 6'h11, 8'hD1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    // Hard stop in case the run never reaches its summary.
    initial begin
        #2000000;
        $display("FAIL timeout: got no summary, expected run to finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/adc_sample_packer.md
# adc_sample_packer

Capture stage between the Giraffe ADC's acknowledge/data outputs and the UART transmitter. The block does five things:
- synchronises `adc_ack`, `adc_ack_sub` and `dout_adc` into the `clk_50M` domain;
- detects each conversion-complete event;
- tags the sample as main or sub-ADC;
- buffers it in a small FIFO;
- drains the FIFO into `uart_tx` through its `wreq`/`rdy` handshake.

This replaces direct edge-to-`wreq` coupling, so samples are not lost while the UART is busy.

## Interface
- `N_bit`, 6, sub-ADC output width.
- `N_data`, 8, UART word width. Must equal `N_bit`+2.
- `FIFO_DEPTH`, 16, sample buffer depth. Power of two, ≥2.
- `SYNC_STAGES`, 2, synchroniser depth on ADC inputs. ≥2.

Ports:
- `clk_50M`  in  1  system clock. One clock; all logic is on its rising edge.
- `nrst`  in  1  reset. Synchronous, active-low.
- `adc_ack`  in  1  main-ADC conversion done (asynchronous to `clk_50M`).
- `adc_ack_sub`  in  1  sub-ADC conversion done (asynchronous).
- `dout_adc`  in  `N_bit`  ADC result. Stable while either ack is high.
- `uart_rdy`  in  1  UART idle/ready.
- `wreq`  out  1  UART write request, one-cycle pulse.
- `wdata`  out  `N_data`  UART write data. Held stable from the `wreq` cycle until the next pop.
- `overflow`  out  1  sticky: a sample was dropped because the FIFO was full.
- `fifo_level`  out  `$clog2(FIFO_DEPTH)+1`  current FIFO occupancy.

## Operation
**Synchronisation**
- `adc_ack`, `adc_ack_sub` and `dout_adc` each pass through `SYNC_STAGES` flops.
- Data and acks are delayed equally, so they remain aligned.

**Event detection**
- `ack_s = ack_sync | ack_sub_sync`.
- An event occurs when `ack_s`=1 and its previous-cycle value `ack_d`=0.
- Exactly one event per rising edge of `ack_s`. A held-high ack produces no further events.

**Tagging**
- Word = `{TAG, dout_sync}`.
- `TAG`=2'b11 if `ack_sync` is 1 in the event cycle. Otherwise `TAG`=2'b00 (sub only).
- If both acks are high, the word gets tag 11.

**FIFO push**
- The word is pushed in the event cycle.
- If the FIFO is full and no pop occurs that cycle, the word is discarded and `overflow` is set to 1.
- `overflow` stays at 1 until reset.

**TX FSM states**
- IDLE:
  - If FIFO not empty and `uart_rdy`=1: pop, register the head into `wdata`, go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - `wreq`=1 for this cycle only. Go to WAIT.
- WAIT:
  - Stay until `uart_rdy`=0 is sampled (UART accepted the request), then go to IDLE.
  - `uart_tx` drops `rdy` the cycle after `wreq`.

**Simultaneous events and boundaries**
- Push and pop in the same cycle when the FIFO is full: both take effect, no overflow, level unchanged.
- Push into an empty FIFO: the word becomes poppable on the next cycle (no bypass).
- FIFO pointers wrap modulo `FIFO_DEPTH`.
- Full/empty are decided by the `fifo_level` count.

**Reset**
- While `nrst`=0 at a clock edge, all of the following are cleared:
  - sync flops and `ack_d` → 0;
  - FIFO emptied (`fifo_level`=0);
  - `wreq`=0, `wdata`=0, `overflow`=0;
  - FSM → IDLE.
- Reset mid-transfer discards all buffered samples and any pending request.

## Timing
- Latency with `SYNC_STAGES`=2, FIFO empty and `uart_rdy`=1:
  - `adc_ack` first sampled high at edge k.
  - Push at edge k+2.
  - Pop and `wdata` valid at edge k+3.
  - `wreq`=1 during the cycle after edge k+4 (REQ).
- Minimum `wreq` spacing is 4 cycles: REQ → WAIT (≥1 cycle) → IDLE → REQ. Spacing is otherwise bounded by the UART frame time.
- `wdata` changes only on a pop and is stable for the whole UART frame.
- `fifo_level` updates on the edge of each push/pop.

## Structure
Shared package/header `giraffe_pkg` holds:
- `TAG_MAIN`=2'b11 and `TAG_SUB`=2'b00;
- TX FSM state encoding (IDLE, REQ, WAIT).

One sub-module, `sync_fifo`, parameterised on width and depth:
- ports: push, pop, din, dout, full, empty, level;
- synchronous active-low reset.

The synchroniser and edge detection stay inline in `adc_sample_packer`.

## Test plan
- **Single main sample:** reset, `uart_rdy`=1, `dout_adc`=6'h2A, pulse `adc_ack` 20 cycles → exactly one `wreq`, `wdata`=8'hEA, 4 cycles after ack sampled; `overflow`=0.
- **Sub sample and tag priority:**
  - `adc_ack_sub` alone, `dout_adc`=6'h05 → `wdata`=8'h05.
  - Both acks together, `dout_adc`=6'h05 → `wdata`=8'hC5.
- **Backpressure:** hold `uart_rdy`=0, issue 16 ack pulses with values 0..15 → `fifo_level`=16, no `wreq`. Release `uart_rdy` → 16 words in order 0..15, tag 11.
- **Overflow:** with FIFO full and `uart_rdy`=0, a 17th ack (value 6'h3F) → dropped, `overflow`=1, level stays 16. After draining, `overflow` is still 1.
- **Full push+pop:** FIFO full, raise `uart_rdy` so the pop coincides with an ack event → level stays 16, no overflow, new word appears last in the output order.
- **Reset mid-operation:** with 5 words buffered and FSM in WAIT, assert `nrst`=0 for one edge → `wreq`=0, `wdata`=0, `fifo_level`=0, FSM IDLE. No `wreq` follows until a new ack arrives.
